reg_status_table: RTL and testbench

Parametrised register status table (RST) for the Tomasulo-style RISC-V core. It records, for every architectural register, whether a result is pending and which reservation-station tag will produce it. It is updated by dispatch (rename) and by the common data bus (CDB), and adds reset, flush, same-cycle CDB bypass on reads, N read ports and an occupancy counter. It sits between the decode/dispatch stage, the register file and the CDB.

---
 rtl/rs_pkg.sv | 15 +
 rtl/rst_popcount.sv | 18 +
 rtl/reg_status_table.sv | 134 +++++++++++++
 tb/tb_reg_status_table.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and default sizes for the rename/issue cluster: register status
// table, reservation stations and CDB arbiter.
package rs_pkg;

  localparam int RS_TAG_W    = 6;
  localparam int RS_NUM_REGS = 32;

  typedef struct packed {
    logic                busy;
    logic [RS_TAG_W-1:0] tag;
  } rst_entry_t;

  localparam rst_entry_t RST_ENTRY_EMPTY = '{busy: 1'b0, tag: {RS_TAG_W{1'b0}}};

endpackage

// File: rtl/rst_popcount.sv
// Population counter: number of set bits in i_vec.
module rst_popcount #(
  parameter int N = 32,
  parameter int W = $clog2(N) + 1
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_count
);

  // Ripple sum of the input bits.
  always_comb begin
    o_count = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      o_count = o_count + W'(i_vec[k]);
    end
  end

endmodule

// File: rtl/reg_status_table.sv
// Register status table: per-architectural-register busy bit and producing tag,
// written by dispatch, cleared by CDB broadcasts, read with same-cycle CDB bypass.
module reg_status_table
  import rs_pkg::*;
#(
  parameter int NUM_REGS = RS_NUM_REGS,
  parameter int TAG_W    = RS_TAG_W,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     disp_en,
  input  logic [ADDR_W-1:0]        disp_addr,
  input  logic [TAG_W-1:0]         disp_tag,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*TAG_W-1:0]  rd_tag,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [ADDR_W:0]          busy_count,
  output logic                     all_clear
);

  logic [NUM_REGS-1:0] r_busy;
  logic [TAG_W-1:0]    r_tag [NUM_REGS];
  logic [ADDR_W:0]     r_busy_count;
  logic                r_all_clear;

  logic [NUM_REGS-1:0] w_match;
  logic [ADDR_W-1:0]   w_match_idx;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [TAG_W-1:0]    w_tag_nxt [NUM_REGS];
  logic [ADDR_W:0]     w_cnt;

  // CAM compare of the CDB tag against every pending entry; entry 0 never matches.
  always_comb begin
    w_match = {NUM_REGS{1'b0}};
    for (int r = 1; r < NUM_REGS; r++) begin
      w_match[r] = cdb_valid & r_busy[r] & (r_tag[r] == cdb_tag);
    end
  end

  // Lowest matching index wins; scanning downward leaves the lowest one last.
  always_comb begin
    w_match_idx = {ADDR_W{1'b0}};
    for (int r = NUM_REGS - 1; r > 0; r--) begin
      if (w_match[r]) begin
        w_match_idx = ADDR_W'(r);
      end else begin
        w_match_idx = w_match_idx;
      end
    end
  end

  // Register-file write port driven by the CDB; suppressed while squashing.
  always_comb begin
    rf_we = (|w_match) & ~flush;
    if (rf_we) begin
      rf_waddr = w_match_idx;
    end else begin
      rf_waddr = {ADDR_W{1'b0}};
    end
  end

  // Next-state per entry: flush, then dispatch, then CDB clear, else hold.
  always_comb begin
    w_busy_nxt   = r_busy;
    w_busy_nxt[0] = 1'b0;
    w_tag_nxt[0]  = {TAG_W{1'b0}};
    for (int r = 1; r < NUM_REGS; r++) begin
      w_tag_nxt[r] = r_tag[r];
      if (flush) begin
        w_busy_nxt[r] = 1'b0;
        w_tag_nxt[r]  = {TAG_W{1'b0}};
      end else if (disp_en && (disp_addr == ADDR_W'(r))) begin
        w_busy_nxt[r] = 1'b1;
        w_tag_nxt[r]  = disp_tag;
      end else if (w_match[r]) begin
        w_busy_nxt[r] = 1'b0;
      end else begin
        w_busy_nxt[r] = r_busy[r];
      end
    end
  end

  // Source-operand reads against current state, with the CDB clear bypassed in.
  always_comb begin
    rd_busy = {NUM_RD{1'b0}};
    rd_tag  = {(NUM_RD*TAG_W){1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      rd_busy[i] = r_busy[rd_addr[i*ADDR_W +: ADDR_W]] & ~w_match[rd_addr[i*ADDR_W +: ADDR_W]];
      if (r_busy[rd_addr[i*ADDR_W +: ADDR_W]]) begin
        rd_tag[i*TAG_W +: TAG_W] = r_tag[rd_addr[i*ADDR_W +: ADDR_W]];
      end else begin
        rd_tag[i*TAG_W +: TAG_W] = {TAG_W{1'b0}};
      end
    end
  end

  rst_popcount #(
    .N(NUM_REGS),
    .W(ADDR_W + 1)
  ) u_popcount (
    .i_vec  (w_busy_nxt),
    .o_count(w_cnt)
  );

  // State and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy       <= {NUM_REGS{1'b0}};
      r_busy_count <= {(ADDR_W+1){1'b0}};
      r_all_clear  <= 1'b1;
      for (int r = 0; r < NUM_REGS; r++) begin
        r_tag[r] <= {TAG_W{1'b0}};
      end
    end else begin
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_cnt;
      r_all_clear  <= (w_cnt == {(ADDR_W+1){1'b0}});
      for (int r = 0; r < NUM_REGS; r++) begin
        r_tag[r] <= w_tag_nxt[r];
      end
    end
  end

  assign busy_count = r_busy_count;
  assign all_clear  = r_all_clear;

endmodule

// File: tb/tb_reg_status_table.sv
// Bench for reg_status_table: directed vector table, then model-checked
// corner sequences and randomized traffic.
module tb_reg_status_table;

  localparam int NR = 32;
  localparam int TW = 6;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          disp_en;
  logic [AW-1:0] disp_addr;
  logic [TW-1:0] disp_tag;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [2*AW-1:0] rd_addr;
  logic [2*TW-1:0] rd_tag;
  logic [1:0]    rd_busy;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [AW:0]   busy_count;
  logic          all_clear;

  int checks;
  int errors;

  bit m_busy [NR];
  int m_tag  [NR];

  reg_status_table dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_en(disp_en), .disp_addr(disp_addr), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .rd_addr(rd_addr), .rd_tag(rd_tag), .rd_busy(rd_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .busy_count(busy_count), .all_clear(all_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int flush, de, da, dt, cv, ct, ra0, ra1;
    int we, wa, b0, b1, t0, t1, tchk, cnt;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input int fl, input int de, input int da, input int dt,
                        input int cv, input int ct, input int ra0, input int ra1);
    flush     = fl[0];
    disp_en   = de[0];
    disp_addr = AW'(da);
    disp_tag  = TW'(dt);
    cdb_valid = cv[0];
    cdb_tag   = TW'(ct);
    rd_addr   = {AW'(ra1), AW'(ra0)};
  endtask

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      m_busy[r] = 1'b0;
      m_tag[r]  = 0;
    end
  endtask

  function automatic bit model_hit(input int r);
    return (r != 0) && cdb_valid && m_busy[r] && (m_tag[r] == int'(cdb_tag));
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int r = 0; r < NR; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  // One clock with the current inputs, every output compared against the model.
  task automatic run_cycle(input string tagname);
    int  first;
    bit  any;
    bit  hits [NR];
    int  a;
    #2;
    any = 1'b0;
    first = 0;
    for (int r = NR - 1; r >= 0; r--) begin
      hits[r] = model_hit(r);
      if (hits[r]) begin
        any = 1'b1;
        first = r;
      end
    end
    chk({tagname, "_rf_we"}, int'(rf_we), int'(any && !flush));
    chk({tagname, "_rf_waddr"}, int'(rf_waddr), (any && !flush) ? first : 0);
    for (int p = 0; p < 2; p++) begin
      a = int'(rd_addr[p*AW +: AW]);
      chk($sformatf("%s_rd_busy%0d", tagname, p), int'(rd_busy[p]), int'(m_busy[a] && !hits[a]));
      if (!hits[a]) begin
        chk($sformatf("%s_rd_tag%0d", tagname, p), int'(rd_tag[p*TW +: TW]), m_busy[a] ? m_tag[a] : 0);
      end
    end
    @(posedge clk);
    if (rst || flush) begin
      model_clear();
    end else begin
      for (int r = 1; r < NR; r++) begin
        if (disp_en && int'(disp_addr) == r) begin
          m_busy[r] = 1'b1;
          m_tag[r]  = int'(disp_tag);
        end else if (hits[r]) begin
          m_busy[r] = 1'b0;
        end
      end
    end
    #1;
    chk({tagname, "_busy_count"}, int'(busy_count), model_count());
    chk({tagname, "_all_clear"}, int'(all_clear), int'(model_count() == 0));
  endtask

  vec_t tv [14];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);

    tv[0]  = '{0,0,0,0,     0,0,     5,3, 0,0, 0,0, 0,0,     3, 0};
    tv[1]  = '{0,1,5,'h12,  0,0,     5,3, 0,0, 0,0, 0,0,     3, 1};
    tv[2]  = '{0,0,0,0,     0,0,     5,3, 0,0, 1,0, 'h12,0,  3, 1};
    tv[3]  = '{0,0,0,0,     1,'h12,  5,3, 1,5, 0,0, 0,0,     2, 0};
    tv[4]  = '{0,0,0,0,     0,0,     5,3, 0,0, 0,0, 0,0,     3, 0};
    tv[5]  = '{0,1,7,'h04,  0,0,     7,5, 0,0, 0,0, 0,0,     3, 1};
    tv[6]  = '{0,1,7,'h09,  1,'h04,  7,5, 1,7, 0,0, 0,0,     2, 1};
    tv[7]  = '{0,0,0,0,     0,0,     7,5, 0,0, 1,0, 'h09,0,  3, 1};
    tv[8]  = '{0,1,0,'h01,  0,0,     0,7, 0,0, 0,1, 0,'h09,  3, 1};
    tv[9]  = '{0,0,0,0,     1,'h01,  0,7, 0,0, 0,1, 0,'h09,  3, 1};
    tv[10] = '{0,1,1,'h21,  0,0,     1,7, 0,0, 0,1, 0,'h09,  3, 2};
    tv[11] = '{0,1,3,'h23,  0,0,     1,3, 0,0, 1,0, 'h21,0,  3, 3};
    tv[12] = '{1,1,2,'h2A,  1,'h21,  1,3, 0,0, 0,1, 0,'h23,  2, 0};
    tv[13] = '{0,0,0,0,     0,0,     2,7, 0,0, 0,0, 0,0,     3, 0};

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_busy_count", int'(busy_count), 0);
    chk("reset_all_clear", int'(all_clear), 1);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      set_in(tv[i].flush, tv[i].de, tv[i].da, tv[i].dt, tv[i].cv, tv[i].ct, tv[i].ra0, tv[i].ra1);
      #2;
      chk($sformatf("v%0d_rf_we", i), int'(rf_we), tv[i].we);
      chk($sformatf("v%0d_rf_waddr", i), int'(rf_waddr), tv[i].wa);
      chk($sformatf("v%0d_rd_busy0", i), int'(rd_busy[0]), tv[i].b0);
      chk($sformatf("v%0d_rd_busy1", i), int'(rd_busy[1]), tv[i].b1);
      if (tv[i].tchk[0]) chk($sformatf("v%0d_rd_tag0", i), int'(rd_tag[TW-1:0]), tv[i].t0);
      if (tv[i].tchk[1]) chk($sformatf("v%0d_rd_tag1", i), int'(rd_tag[2*TW-1:TW]), tv[i].t1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy_count", i), int'(busy_count), tv[i].cnt);
      chk($sformatf("v%0d_all_clear", i), int'(all_clear), int'(tv[i].cnt == 0));
    end

    // Table ends with an empty table, so the model starts empty too.
    model_clear();

    // Duplicate tags: both entries clear, lowest index reported.
    set_in(0, 1, 9, 'h3F, 0, 0, 9, 4);    run_cycle("dup_a");
    set_in(0, 1, 4, 'h3F, 0, 0, 9, 4);    run_cycle("dup_b");
    set_in(0, 0, 0, 0, 1, 'h3F, 9, 4);    run_cycle("dup_cdb");
    set_in(0, 0, 0, 0, 0, 0, 9, 4);       run_cycle("dup_after");

    // Reset mid-stream with dispatch and matching CDB in the same cycle.
    set_in(0, 1, 10, 'h0A, 0, 0, 10, 11); run_cycle("rst_a");
    set_in(0, 1, 11, 'h0B, 0, 0, 10, 11); run_cycle("rst_b");
    rst = 1'b1;
    set_in(0, 1, 12, 'h0C, 1, 'h0A, 10, 11); run_cycle("rst_hit");
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 12, 11);     run_cycle("rst_after");

    // Randomized traffic; CDB mostly carries a tag currently held in the table.
    for (int n = 0; n < 600; n++) begin
      int pick;
      int ct;
      rst = ($urandom_range(0, 79) == 0);
      pick = $urandom_range(0, NR - 1);
      ct = ($urandom_range(0, 9) < 7) ? m_tag[pick] : int'($urandom_range(0, 63));
      set_in(int'($urandom_range(0, 29) == 0), int'($urandom_range(0, 1)),
             int'($urandom_range(0, NR - 1)), int'($urandom_range(0, 63)),
             int'($urandom_range(0, 1)), ct,
             int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)));
      run_cycle("rnd");
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
